// File: rtl/cfu_simd_mac.sv
// SIMD packed-int8 dot-product MAC CFU with NUM_ACC accumulators plus scalar add/sub/mul.
// Latency: 1 cycle for non-MAC commands, 2 cycles for MAC. One command in flight; cmd_ready only in IDLE.
// Backpressure: the response is held stable until rsp_ready. Optional CFU_SIMD_MAC_SAT_EN saturates MAC/LOAD.
module cfu_simd_mac #(
    parameter int LANES     = 4,
    parameter int NUM_ACC   = 4,
    parameter int ACC_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

`ifdef CFU_SIMD_MAC_SAT_EN
    // Headroom so products and the lane sum cannot wrap before the final clamp.
    localparam int PW = ACC_WIDTH + 3;
    localparam int SW = 40;
`else
    localparam int PW = ACC_WIDTH;
    localparam int SW = ACC_WIDTH;
`endif
    localparam int KW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    typedef enum logic [1:0] {IDLE, MAC_S1, RESP} state_t;

    state_t state_q, state_d;

    logic [ACC_WIDTH-1:0]  acc [NUM_ACC];
    logic signed [31:0]    input_offset;
    logic signed [PW-1:0]  prod_r [LANES];
    logic [KW-1:0]         k_r;
    logic [31:0]           rsp_dat;

    logic [2:0]            funct3;
    logic [3:0]            op;
    logic [KW-1:0]         k;
    logic                  accept;
    logic                  is_mac;
    logic                  acc_we;
    logic                  off_we;
    logic [ACC_WIDTH-1:0]  acc_wdat;
    logic [31:0]           imm_res;
    logic signed [PW-1:0]  off_pw;
    logic signed [PW-1:0]  prod_n [LANES];
    logic signed [SW-1:0]  lane_sum;
    logic signed [SW-1:0]  mac_total;
    logic [ACC_WIDTH-1:0]  mac_acc;

    function automatic logic [ACC_WIDTH-1:0] fit_acc(input logic signed [SW-1:0] v);
`ifdef CFU_SIMD_MAC_SAT_EN
        if (v[SW-1:ACC_WIDTH-1] != {(SW-ACC_WIDTH+1){v[SW-1]}})
            fit_acc = {v[SW-1], {(ACC_WIDTH-1){~v[SW-1]}}};
        else
            fit_acc = v[ACC_WIDTH-1:0];
`else
        fit_acc = v[ACC_WIDTH-1:0];
`endif
    endfunction

    function automatic logic [31:0] ext32(input logic [ACC_WIDTH-1:0] v);
        ext32 = 32'($signed(v));
    endfunction

    assign funct3    = cmd_payload_function_id[2:0];
    assign op        = cmd_payload_function_id[6:3];
    assign k         = KW'(cmd_payload_function_id[9:7] & 3'(NUM_ACC - 1));
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign off_pw    = PW'(input_offset);
    assign rsp_payload_outputs_0 = rsp_dat;

    always_comb begin
        is_mac   = 1'b0;
        acc_we   = 1'b0;
        off_we   = 1'b0;
        acc_wdat = '0;
        imm_res  = '0;
        case (funct3)
            3'd0: imm_res = cmd_payload_inputs_0 + cmd_payload_inputs_1;
            3'd1: imm_res = cmd_payload_inputs_0 - cmd_payload_inputs_1;
            3'd2: imm_res = cmd_payload_inputs_0 * cmd_payload_inputs_1;
            3'd3: begin
                case (op)
                    4'd0: is_mac = 1'b1;
                    4'd1: acc_we = 1'b1;
                    4'd2: off_we = 1'b1;
                    4'd3: imm_res = ext32(acc[k]);
                    4'd4: begin
                        acc_we   = 1'b1;
                        acc_wdat = fit_acc(SW'($signed(cmd_payload_inputs_0)));
                        imm_res  = ext32(acc_wdat);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_n[i] = PW'($signed(cmd_payload_inputs_0[8*i +: 8]))
                      * (PW'($signed(cmd_payload_inputs_1[8*i +: 8])) + off_pw);
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + SW'(prod_r[i]);
        end
        mac_total = SW'($signed(acc[k_r])) + lane_sum;
        mac_acc   = fit_acc(mac_total);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = is_mac ? MAC_S1 : RESP;
            MAC_S1:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_dat      <= '0;
            input_offset <= '0;
            k_r          <= '0;
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            for (int i = 0; i < LANES; i++) prod_r[i] <= '0;
        end else begin
            if (accept) begin
                k_r <= k;
                for (int i = 0; i < LANES; i++) prod_r[i] <= prod_n[i];
                if (!is_mac) rsp_dat <= imm_res;
                if (acc_we) acc[k] <= acc_wdat;
                if (off_we) input_offset <= $signed(cmd_payload_inputs_0);
            end
            // Accumulator commits only on the edge entering RESP, so a reset in MAC_S1 drops it.
            if (state_q == MAC_S1) begin
                acc[k_r] <= mac_acc;
                rsp_dat  <= ext32(mac_acc);
            end
        end
    end

endmodule

// File: tb/tb_cfu_simd_mac.sv
// Self-checking bench for cfu_simd_mac: scoreboard queue of expected responses, one task per scenario.
module tb_cfu_simd_mac;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id = '0;
    logic [31:0] cmd_payload_inputs_0 = '0;
    logic [31:0] cmd_payload_inputs_1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_payload_outputs_0;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];

    localparam logic [3:0] OP_MAC = 4'd0, OP_CLR = 4'd1, OP_OFF = 4'd2, OP_RD = 4'd3, OP_LD = 4'd4;
`ifdef CFU_SIMD_MAC_SAT_EN
    localparam logic [31:0] SAT_EXP = 32'h7FFFFFFF;
`else
    localparam logic [31:0] SAT_EXP = 32'h80000004;
`endif

    always #5 clk = ~clk;

    cfu_simd_mac dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    function automatic logic [9:0] fid(input logic [2:0] k, input logic [3:0] op, input logic [2:0] f3);
        return {k, op, f3};
    endfunction

    // Drives one command, measures accept-edge-to-rsp_valid latency, consumes the response.
    task automatic issue(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output int lat);
        int w;
        @(negedge clk);
        cmd_payload_function_id = f;
        cmd_payload_inputs_0 = a;
        cmd_payload_inputs_1 = b;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!rsp_valid) begin
            data = 'x;
            lat = -1;
        end else begin
            data = rsp_payload_outputs_0;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        int lat;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if (rsp_payload_outputs_0 !== 32'h0) $display("FAIL reset payload: got %h want 0", rsp_payload_outputs_0); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL reset cmd_ready: got %b want 1", cmd_ready); else passed++;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            issue(fid(3'(i), OP_RD, 3'd3), 32'h0, 32'h0, got, lat);
            exp = exp_q.pop_front();
            checks++; if (got !== exp) $display("FAIL reset read acc%0d: got %h want %h", i, got, exp); else passed++;
        end
    endtask

    task automatic test_mac();
        logic [9:0] f [3];
        logic [31:0] a [3], b [3], ex [3];
        int lt [3];
        logic [31:0] got, exp;
        int lat;
        f  = '{fid(3'd0, OP_OFF, 3'd3), fid(3'd0, OP_MAC, 3'd3), fid(3'd0, OP_MAC, 3'd3)};
        a  = '{32'd1, 32'h01020304, 32'h01020304};
        b  = '{32'd0, 32'h01010101, 32'h01010101};
        ex = '{32'd0, 32'd20, 32'd40};
        lt = '{1, 2, 2};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex[i]);
            issue(f[i], a[i], b[i], got, lat);
            exp = exp_q.pop_front();
            checks++; if (got !== exp) $display("FAIL mac[%0d] data: got %h want %h", i, got, exp); else passed++;
            checks++; if (lat !== lt[i]) $display("FAIL mac[%0d] latency: got %0d want %0d", i, lat, lt[i]); else passed++;
        end
    endtask

    task automatic test_independent();
        logic [9:0] f [3];
        logic [31:0] a [3], b [3], ex [3];
        logic [31:0] got, exp;
        int lat;
        f  = '{fid(3'd0, OP_OFF, 3'd3), fid(3'd1, OP_MAC, 3'd3), fid(3'd0, OP_RD, 3'd3)};
        a  = '{32'd128, 32'h7F7F7F7F, 32'h0};
        b  = '{32'd0, 32'h80808080, 32'h0};
        ex = '{32'd0, 32'd0, 32'd40};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex[i]);
            issue(f[i], a[i], b[i], got, lat);
            exp = exp_q.pop_front();
            checks++; if (got !== exp) $display("FAIL indep[%0d] data: got %h want %h", i, got, exp); else passed++;
        end
    endtask

    task automatic test_saturation();
        logic [9:0] f [4];
        logic [31:0] a [4], b [4], ex [4];
        logic [31:0] got, exp;
        int lat;
        f  = '{fid(3'd0, OP_OFF, 3'd3), fid(3'd2, OP_LD, 3'd3), fid(3'd2, OP_MAC, 3'd3), fid(3'd2, OP_RD, 3'd3)};
        a  = '{32'd1, 32'h7FFFFFF0, 32'h01020304, 32'h0};
        b  = '{32'd0, 32'h0, 32'h01010101, 32'h0};
        ex = '{32'd0, 32'h7FFFFFF0, SAT_EXP, SAT_EXP};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ex[i]);
            issue(f[i], a[i], b[i], got, lat);
            exp = exp_q.pop_front();
            checks++; if (got !== exp) $display("FAIL sat[%0d] data: got %h want %h", i, got, exp); else passed++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] got, exp;
        int lat;
        @(negedge clk);
        cmd_payload_function_id = fid(3'd3, OP_MAC, 3'd3);
        cmd_payload_inputs_0 = 32'h01020304;
        cmd_payload_inputs_1 = 32'h01010101;
        cmd_valid = 1'b1;
        exp_q.push_back(32'd20);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        exp = exp_q.pop_front();
        checks++; if (lat !== 2) $display("FAIL stall latency: got %0d want 2", lat); else passed++;
        // Offer a new add while the response is stalled; it must not be taken.
        cmd_payload_function_id = fid(3'd0, 4'd0, 3'd0);
        cmd_payload_inputs_0 = 32'd1;
        cmd_payload_inputs_1 = 32'd1;
        cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1) $display("FAIL stall[%0d] rsp_valid: got %b want 1", c, rsp_valid); else passed++;
            checks++; if (rsp_payload_outputs_0 !== exp) $display("FAIL stall[%0d] payload: got %h want %h", c, rsp_payload_outputs_0, exp); else passed++;
            checks++; if (cmd_ready !== 1'b0) $display("FAIL stall[%0d] cmd_ready: got %b want 0", c, cmd_ready); else passed++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL stall release cmd_ready: got %b want 1", cmd_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL stall release rsp_valid: got %b want 0", rsp_valid); else passed++;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL stall no extra rsp: got %b want 0", rsp_valid); else passed++;
        exp_q.push_back(32'd20);
        issue(fid(3'd3, OP_RD, 3'd3), 32'h0, 32'h0, got, lat);
        exp = exp_q.pop_front();
        checks++; if (got !== exp) $display("FAIL stall read acc3: got %h want %h", got, exp); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        int lat;
        @(negedge clk);
        cmd_payload_function_id = fid(3'd0, OP_MAC, 3'd3);
        cmd_payload_inputs_0 = 32'h01020304;
        cmd_payload_inputs_1 = 32'h01010101;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL abort rsp_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if (rsp_payload_outputs_0 !== 32'h0) $display("FAIL abort payload: got %h want 0", rsp_payload_outputs_0); else passed++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL abort after rsp_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL abort after cmd_ready: got %b want 1", cmd_ready); else passed++;
        exp_q.push_back(32'h0);
        issue(fid(3'd0, OP_RD, 3'd3), 32'h0, 32'h0, got, lat);
        exp = exp_q.pop_front();
        checks++; if (got !== exp) $display("FAIL abort read acc0: got %h want %h", got, exp); else passed++;
        // Offset was reset to 0, so the same operands now sum to 10.
        exp_q.push_back(32'd10);
        issue(fid(3'd0, OP_MAC, 3'd3), 32'h01020304, 32'h01010101, got, lat);
        exp = exp_q.pop_front();
        checks++; if (got !== exp) $display("FAIL abort mac offset0: got %h want %h", got, exp); else passed++;
    endtask

    task automatic test_scalar();
        logic [9:0] f [8];
        logic [31:0] a [8], b [8], ex [8];
        logic [31:0] got, exp;
        int lat;
        f  = '{fid(3'd0, 4'd0, 3'd0), fid(3'd0, 4'd0, 3'd1), fid(3'd0, 4'd0, 3'd2), fid(3'd0, 4'd0, 3'd5),
               fid(3'd0, 4'd7, 3'd3), fid(3'd0, OP_RD, 3'd3), fid(3'd0, OP_CLR, 3'd3), fid(3'd0, OP_RD, 3'd3)};
        a  = '{32'd5, 32'd3, 32'h00010000, 32'h01020304, 32'h01020304, 32'h0, 32'h12345678, 32'h0};
        b  = '{32'd7, 32'd5, 32'h00010000, 32'h01010101, 32'h01010101, 32'h0, 32'h0, 32'h0};
        ex = '{32'd12, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h0, 32'd10, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(ex[i]);
            issue(f[i], a[i], b[i], got, lat);
            exp = exp_q.pop_front();
            checks++; if (got !== exp) $display("FAIL scalar[%0d] data: got %h want %h", i, got, exp); else passed++;
            checks++; if (lat !== 1) $display("FAIL scalar[%0d] latency: got %0d want 1", i, lat); else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        test_reset();
        test_mac();
        test_independent();
        test_saturation();
        test_stall();
        test_reset_mid();
        test_scalar();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
